// File: rtl/pipe_muldiv_unit_if.sv
// pipe_muldiv_unit_if: EX-stage mul/div request and HI/LO response bundle
interface pipe_muldiv_unit_if #(parameter int WIDTH = 32);
   logic             start;
   logic [3:0]       alu_control;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             mt_hi;
   logic             mt_lo;
   logic [WIDTH-1:0] mt_data;
   logic             mf_req;
   logic             busy;
   logic             stall_req;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   modport master (output start, alu_control, op_a, op_b, mt_hi, mt_lo, mt_data, mf_req,
                   input busy, stall_req, done, hi, lo);
   modport slave (input start, alu_control, op_a, op_b, mt_hi, mt_lo, mt_data, mf_req,
                  output busy, stall_req, done, hi, lo);
endinterface

// File: rtl/pipe_muldiv_unit.sv
// pipe_muldiv_unit: iterative MULT/MULTU/DIV/DIVU unit owning HI/LO
// Magnitudes are iterated unsigned; a single FIX cycle applies the sign correction.
module pipe_muldiv_unit #(parameter int WIDTH = 32) (
   input logic               clk,
   input logic               reset,
   pipe_muldiv_unit_if.slave bus
);
   localparam int CW = $clog2(WIDTH);
   typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
   state_t             state_q;
   logic [CW-1:0]      cnt_q;
   logic [WIDTH-1:0]   a_q, b_q, hi_q, lo_q;
   logic [2*WIDTH-1:0] acc_q, acc_d, prod_fix;
   logic               neg_q, neg_r_q, div_q, done_q;
   logic [WIDTH:0]     sum, trial;
   logic [WIDTH-1:0]   abs_a, abs_b, a_init, q_fix, r_fix;
   logic               valid, sgn, is_mul, b_zero;
   assign valid  = bus.start && bus.alu_control[3:2] == 2'b10;
   assign sgn    = ~bus.alu_control[0];
   assign is_mul = bus.alu_control[1];
   assign b_zero = bus.op_b == '0;
   assign abs_a  = (sgn && bus.op_a[WIDTH-1]) ? -bus.op_a : bus.op_a;
   assign abs_b  = (sgn && bus.op_b[WIDTH-1]) ? -bus.op_b : bus.op_b;
   // A raw dividend with a zero divisor makes the restoring loop yield Lo=all-ones, Hi=OpA
   assign a_init = (!is_mul && b_zero) ? bus.op_a : abs_a;
   assign sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, acc_q[0] ? a_q : '0};
   assign trial  = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, b_q};
   always_comb acc_d = (state_q == MUL) ? {sum, acc_q[WIDTH-1:1]} :
                       trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0} :
                       {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
   assign prod_fix = neg_q ? -acc_q : acc_q;
   assign q_fix    = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
   assign r_fix    = neg_r_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
   assign bus.busy      = state_q != IDLE && !reset;
   assign bus.stall_req = bus.busy && (bus.start || bus.mt_hi || bus.mt_lo || bus.mf_req);
   assign bus.done      = done_q && !reset;
   assign bus.hi        = hi_q;
   assign bus.lo        = lo_q;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         neg_q   <= 1'b0;
         neg_r_q <= 1'b0;
         div_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.mt_hi) hi_q <= bus.mt_data;
               if (bus.mt_lo) lo_q <= bus.mt_data;
               if (valid) begin
                  a_q     <= a_init;
                  b_q     <= abs_b;
                  acc_q   <= {{WIDTH{1'b0}}, is_mul ? abs_b : a_init};
                  neg_q   <= sgn && (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]) && !b_zero;
                  neg_r_q <= sgn && bus.op_a[WIDTH-1] && !b_zero && !is_mul;
                  div_q   <= !is_mul;
                  cnt_q   <= '0;
                  state_q <= is_mul ? MUL : DIV;
               end
            end
            MUL, DIV: begin
               acc_q <= acc_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CW'(WIDTH - 1)) state_q <= FIX;
            end
            FIX: begin
               hi_q    <= div_q ? r_fix : prod_fix[2*WIDTH-1:WIDTH];
               lo_q    <= div_q ? q_fix : prod_fix[WIDTH-1:0];
               done_q  <= 1'b1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_pipe_muldiv_unit.sv
// tb_pipe_muldiv_unit: directed vectors, expected HI/LO queued at issue and
// checked by a monitor on every Done pulse.
module tb_pipe_muldiv_unit;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int compared = 0;
   int mismatched = 0;
   logic [63:0] exp_q[$];
   pipe_muldiv_unit_if #(.WIDTH(32)) bus ();
   pipe_muldiv_unit #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   always @(negedge clk) begin
      if (bus.done) begin
         if (exp_q.size() == 0) chk("unexpected_done", {bus.hi, bus.lo}, 64'hx);
         else chk("hilo", {bus.hi, bus.lo}, exp_q.pop_front());
      end
   end
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      bus.start = 1'b1;
      bus.alu_control = c;
      bus.op_a = a;
      bus.op_b = b;
      step();
      bus.start = 1'b0;
   endtask
   task automatic wait_idle();
      int n = 0;
      while (bus.busy && n < 40) begin
         n++;
         step();
      end
      chk("busy_cycles", n, 33);
   endtask
   task automatic run(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] eh, input logic [31:0] el);
      exp_q.push_back({eh, el});
      issue(c, a, b);
      wait_idle();
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end
   initial begin
      logic [31:0] h0, l0;
      int n;
      bus.start = 0; bus.alu_control = 0; bus.op_a = 0; bus.op_b = 0;
      bus.mt_hi = 0; bus.mt_lo = 0; bus.mt_data = 0; bus.mf_req = 0;
      repeat (3) step();
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_hilo", {bus.hi, bus.lo}, 0);
      reset = 1'b0;
      step();
      // Mt writes in IDLE: no stall, visible next cycle
      bus.mt_lo = 1; bus.mt_data = 32'h55; bus.mf_req = 1;
      #1 chk("idle_stall", bus.stall_req, 0);
      step();
      bus.mt_lo = 0; bus.mf_req = 0;
      chk("mtlo", bus.lo, 32'h55);
      bus.mt_hi = 1; bus.mt_data = 32'h66;
      step();
      bus.mt_hi = 0;
      chk("mthi", bus.hi, 32'h66);
      // Reset during a DIV discards it
      issue(4'b1000, 32'd100, 32'd7);
      repeat (9) step();
      chk("div_busy_mid", bus.busy, 1);
      reset = 1'b1;
      #1;
      chk("mid_rst_busy", bus.busy, 0);
      chk("mid_rst_hilo", {bus.hi, bus.lo}, 0);
      chk("mid_rst_done", bus.done, 0);
      step();
      reset = 1'b0;
      step();
      run(4'b1011, 32'd3, 32'd5, 32'd0, 32'd15);
      run(4'b1010, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFE);
      run(4'b1011, 32'hFFFFFFFF, 32'h2, 32'h1, 32'hFFFFFFFE);
      run(4'b1000, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD);
      run(4'b1000, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
      run(4'b1001, 32'd100, 32'd7, 32'd2, 32'd14);
      run(4'b1000, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);
      run(4'b1000, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF);
      run(4'b1001, 32'h1234, 32'd0, 32'h1234, 32'hFFFFFFFF);
      // Busy MULT with stalled requesters and changing operands
      h0 = bus.hi; l0 = bus.lo;
      exp_q.push_back(64'hFFFFFFFF_FFFFFFEB);
      bus.start = 1; bus.alu_control = 4'b1010; bus.op_a = 32'd7; bus.op_b = 32'hFFFFFFFD;
      step();
      n = 0;
      while (bus.busy && n < 40) begin
         n++;
         if (n == 5) begin
            bus.mf_req = 1; bus.mt_hi = 1; bus.mt_data = 32'hAAAA0000;
            bus.alu_control = 4'b1011; bus.op_a = 32'd1; bus.op_b = 32'd1;
         end
         if (n >= 5) begin
            chk("busy_stall", bus.stall_req, 1);
            chk("busy_hilo_hold", {bus.hi, bus.lo}, {h0, l0});
         end
         step();
      end
      chk("busy_cycles", n, 33);
      chk("idle_no_stall", bus.stall_req, 0);
      bus.start = 0; bus.mf_req = 0; bus.mt_hi = 0;
      step();
      chk("no_reaccept", bus.busy, 0);
      // Start and MtHi together: Mt lands at t0, writeback overwrites
      exp_q.push_back({32'd0, 32'd4});
      bus.mt_hi = 1; bus.mt_data = 32'h9;
      issue(4'b1011, 32'd2, 32'd2);
      bus.mt_hi = 0;
      chk("mt_with_start", bus.hi, 32'h9);
      wait_idle();
      repeat (3) step();
      chk("queue_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/pipe_muldiv_unit.md
Name: pipe_muldiv_unit

Overview:
- Multi-cycle HI/LO execution unit for the pipelined MIPS core.
- Sequences MULT/MULTU/DIV/DIVU using the 4-bit ALU control codes 1000/1001/1010/1011 issued by the ALU decoder.
- Owns the HI/LO architectural registers, services MTHI/MTLO/MFHI/MFLO, and raises a stall request to the hazard unit while an operation is in flight.

Parameters:
- WIDTH, 32: operand width. Also the iteration count. HI/LO are each WIDTH bits.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- Start  in  1  EX-stage instruction is a mul/div; qualified by AluControl
- AluControl  in  4  1000 DIV, 1001 DIVU, 1010 MULT, 1011 MULTU; other codes ignore Start
- OpA  in  WIDTH  rs value (multiplicand / dividend)
- OpB  in  WIDTH  rt value (multiplier / divisor)
- MtHi  in  1  MTHI in EX
- MtLo  in  1  MTLO in EX
- MtData  in  WIDTH  rs value for MTHI/MTLO
- MfReq  in  1  MFHI or MFLO in EX
- Busy  out  1  state != IDLE
- StallReq  out  1  Busy && (Start || MtHi || MtLo || MfReq), combinational
- Done  out  1  registered one-cycle pulse, the cycle after HI/LO writeback
- Hi  out  WIDTH  HI register
- Lo  out  WIDTH  LO register

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - state=IDLE; Hi=Lo=0; Busy=0; Done=0.
  - Iteration counter and internal accumulators cleared.
  - Any in-flight operation is discarded.
- States: IDLE, MUL, DIV, FIX.
- IDLE:
  - Start with a valid code is accepted at edge t0.
  - Capture |OpA| and |OpB| for signed codes (raw values for unsigned codes).
  - Capture the result sign flags. Clear counter. Go to MUL or DIV.
- MUL: shift-add, one multiplier bit per cycle, 2*WIDTH-bit accumulator.
- DIV: restoring division, one quotient bit per cycle.
- Counter and exit from MUL/DIV:
  - Counter increments each cycle.
  - On the edge where counter==WIDTH-1 (edge t32 for WIDTH=32), go to FIX.
- FIX:
  - Apply sign correction.
  - At edge t33: write Hi/Lo, go to IDLE, set Done=1 for the next cycle.
  - Busy is high from just after t0 through t33 (33 cycles). New results are visible on Hi/Lo right after t33.
- Sign rules:
  - MULT: 2*WIDTH product negated when sign(OpA)!=sign(OpB).
  - DIV: quotient negated when signs differ; remainder takes the sign of the dividend.
  - Most-negative / -1: Lo=0x80000000, Hi=0 (wrap, no trap).
- Results:
  - MUL*: Hi=product[63:32], Lo=product[31:0].
  - DIV*: Lo=quotient, Hi=remainder.
- Divide by zero (DIV or DIVU):
  - Still takes the full 33 cycles.
  - Lo=0xFFFFFFFF, Hi=original OpA (unsigned path result, no sign fix).
- While Busy:
  - Start, MtHi, MtLo and MfReq have no effect on state or registers.
  - StallReq holds the requester in EX until Busy falls.
  - Operands are captured only at t0, so input changes mid-operation are ignored.
- MTHI/MTLO in IDLE: write MtData into Hi/Lo at the next edge. Zero latency: the value is visible on the following cycle.
- Start with MtHi/MtLo in the same IDLE cycle: the Mt write applies at t0; the operation's writeback at t33 overwrites both registers.
- MfReq in IDLE: no stall. Hi/Lo are read directly by the pipeline.
- Done, Busy and StallReq are never asserted in the same cycle as reset.

Test Plan:
- Reset mid-DIV at cycle 10 → Busy=0, Hi=Lo=0 immediately. Next MULTU 3×5 → Lo=15, Hi=0 after 33 Busy cycles; Done pulses once.
- MULT 0xFFFFFFFF×0x00000002 → Hi=0xFFFFFFFF, Lo=0xFFFFFFFE. MULTU with the same operands → Hi=0x00000001, Lo=0xFFFFFFFE.
- DIV 7 / 0xFFFFFFFE (-2) → Lo=0xFFFFFFFD, Hi=1. DIV 0xFFFFFFF9 (-7) / 2 → Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. DIVU 100/7 → Lo=14, Hi=2.
- DIV 0x80000000 / 0xFFFFFFFF → Lo=0x80000000, Hi=0. DIVU 0x1234/0 → Lo=0xFFFFFFFF, Hi=0x1234, Busy for 33 cycles.
- Checks during a busy MULT:
  - MfReq at cycle 5 → StallReq=1 until Busy falls; Hi/Lo unchanged until t33.
  - MtHi with 0xAAAA0000 at cycle 5 → ignored.
  - Start held high with changed operands → not re-accepted until IDLE.
- In IDLE, MtLo=0x55 → Lo=0x55 next cycle with no stall. Same-cycle Start(MULTU 2×2)+MtHi(0x9) → Hi=0x9 after t0, then Hi=0, Lo=4 after t33.
